cvxif_result_buffer: RTL and testbench
======================================

# cvxif_result_buffer

Result-side decoupling FIFO between the CV-X-IF example coprocessor and the CPU result port. It captures every coprocessor result (id, data, we) and presents the results in order to the CPU with a valid/ready handshake. The coprocessor no longer needs `x_result_ready` held permanently high. An early stall output lets the coprocessor issue logic deassert `x_issue_ready` before the buffer can overflow.

## Interface
- `Depth`, 4: number of result entries; power of two, at least 2.
- `DataWidth`, 64: width of result data.
- `IdWidth`, `cvxif_pkg::X_ID_WIDTH`: width of the instruction id.
- `clk_i` input 1: clock; all state on the rising edge.
- `rst_i` input 1: reset, asynchronous, active-high.
- `in_valid_i` input 1: coprocessor result valid.
- `in_id_i` input IdWidth: result instruction id.
- `in_data_i` input DataWidth: result data.
- `in_we_i` input 1: result requests register writeback.
- `in_ready_o` output 1: buffer accepts the result this cycle.
- `out_valid_o` output 1: head entry valid toward the CPU.
- `out_id_o` output IdWidth: head id.
- `out_data_o` output DataWidth: head data.
- `out_we_o` output 1: head writeback flag.
- `out_ready_i` input 1: CPU takes the head this cycle (`x_result_ready`).
- `issue_stall_o` output 1: coprocessor must not accept new instructions.
- `count_o` output $clog2(Depth)+1: current occupancy.
- `overflow_o` output 1: sticky flag; a result was presented while the buffer was full.

## Operation
- Circular buffer of Depth entries {id, data, we}.
  - Write pointer and read pointer are each $clog2(Depth) bits and wrap naturally modulo Depth.
  - Occupancy counter is separate, 0..Depth.
- Push = `in_valid_i & in_ready_o`; writes the entry at the write pointer, then increments the write pointer.
- Pop = `out_valid_o & out_ready_i`; increments the read pointer.
- `in_ready_o = (count_o != Depth)`. It does not depend on `out_ready_i`: no push into a full buffer even when a pop happens in the same cycle.
- `out_valid_o = (count_o != 0)`. The out_* fields show the head entry combinationally from storage.
  - When the buffer is empty, out_id/data/we are 0.
- Count update:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on simultaneous push and pop.
  - Unchanged on neither.
- `issue_stall_o = (count_o >= Depth-1)`. This reserves one slot for a multi-cycle execution that completes after issue has been closed.
- Overflow: `in_valid_i` asserted while `count_o == Depth`.
  - The result is dropped and `overflow_o` is set.
  - `overflow_o` stays set until reset. It never clears otherwise.
- Ordering: results leave in arrival order. Ids are not checked or reordered.
- Entries with we=0 (fill-only completions) are buffered and forwarded like any other result. The CPU needs them to retire.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert): pointers, count and `overflow_o` go to 0.
  - Hence `out_valid_o`=0, `in_ready_o`=1, `issue_stall_o`=0, out_* = 0.
  - Storage contents are not reset.
- Latency:
  - A result pushed in cycle N is visible at the output in cycle N+1 at the earliest.
  - There is no same-cycle bypass.
- Throughput: one push and one pop per cycle in steady state.
- The CPU may hold `out_ready_i` low indefinitely. The head entry stays stable until it is popped.
- Reset asserted mid-operation discards all entries immediately. There is no partial drain.
- Full boundary:
  - Push when count = Depth-1 raises `in_ready_o` low and `issue_stall_o` stays high in the next cycle.
  - A pop from full lowers count to Depth-1 and `in_ready_o` returns high the next cycle.
- Pointer wrap: after Depth pushes the write pointer returns to 0. Data integrity must hold across the wrap.

## Test plan
- Reset, then single result:
  - Push id=3, data=0xDEAD, we=1 with `out_ready_i`=1.
  - Expect `out_valid_o`=1 the next cycle carrying 3/0xDEAD/1, popped that same cycle.
  - Expect count to return 0.
- Fill to full with `out_ready_i`=0 by pushing ids 0..3 on consecutive cycles:
  - `issue_stall_o` rises once count=3.
  - `in_ready_o`=0 at count=4.
  - A fifth push (id=4) sets `overflow_o`=1, and count stays 4.
- Drain after full with `out_ready_i`=1 for 4 cycles:
  - Ids come out in order 0,1,2,3.
  - `overflow_o` remains 1.
  - Dropped id 4 never appears.
- Simultaneous push/pop at count=2 for 10 cycles with incrementing data:
  - Count stays 2.
  - Output data lags input by exactly 2 entries.
  - Pointers wrap more than once with no corruption.
- we=0 passthrough: push id=5, we=0, data=0 → output shows id=5, we=0.
- Reset mid-stream: assert `rst_i` with count=3.
  - Outputs go to reset values asynchronously.
  - After release the first new push (id=7) is the first output.

Source files
------------

// File: rtl/cvxif_result_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : cvxif_result_buffer
//  Purpose  : In-order result FIFO between the CV-X-IF coprocessor and the
//             CPU result port. Decouples the coprocessor from x_result_ready
//             and raises an early issue stall while one slot is still free.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk_i          clock, rising edge
//    rst_i          asynchronous active-high reset
//    in_valid_i     coprocessor result valid
//    in_id_i        result instruction id
//    in_data_i      result data
//    in_we_i        result requests register writeback
//    in_ready_o     buffer accepts the result this cycle
//    out_valid_o    head entry valid toward the CPU
//    out_id_o       head id (0 when empty)
//    out_data_o     head data (0 when empty)
//    out_we_o       head writeback flag (0 when empty)
//    out_ready_i    CPU takes the head this cycle (x_result_ready)
//    issue_stall_o  coprocessor must not accept new instructions
//    count_o        current occupancy, 0..Depth
//    overflow_o     sticky: a result arrived while the buffer was full
// ============================================================================

package cvxif_pkg;
  localparam int X_ID_WIDTH = 4;
endpackage

module cvxif_result_buffer #(
  parameter int Depth     = 4,
  parameter int DataWidth = 64,
  parameter int IdWidth   = cvxif_pkg::X_ID_WIDTH
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   in_valid_i,
  input  logic [IdWidth-1:0]     in_id_i,
  input  logic [DataWidth-1:0]   in_data_i,
  input  logic                   in_we_i,
  output logic                   in_ready_o,
  output logic                   out_valid_o,
  output logic [IdWidth-1:0]     out_id_o,
  output logic [DataWidth-1:0]   out_data_o,
  output logic                   out_we_o,
  input  logic                   out_ready_i,
  output logic                   issue_stall_o,
  output logic [$clog2(Depth):0] count_o,
  output logic                   overflow_o
);

  localparam int c_ptr_w = $clog2(Depth);
  localparam int c_cnt_w = c_ptr_w + 1;

  localparam logic [c_cnt_w-1:0] c_full  = c_cnt_w'(Depth);
  localparam logic [c_cnt_w-1:0] c_stall = c_cnt_w'(Depth - 1);

  // Storage carries no reset; validity is tracked solely by the counter.
  logic [IdWidth-1:0]   r_mem_id   [Depth];
  logic [DataWidth-1:0] r_mem_data [Depth];
  logic                 r_mem_we   [Depth];

  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;
  logic               r_overflow;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  assign w_full  = (r_count == c_full);
  assign w_empty = (r_count == '0);

  // Ready depends only on occupancy, so a full buffer refuses a push even
  // when the CPU pops in the same cycle.
  assign w_push = in_valid_i & ~w_full;
  assign w_pop  = ~w_empty & out_ready_i;

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem_id[r_wr_ptr]   <= in_id_i;
      r_mem_data[r_wr_ptr] <= in_data_i;
      r_mem_we[r_wr_ptr]   <= in_we_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_w'(1);
        2'b01:   r_count <= r_count - c_cnt_w'(1);
        default: r_count <= r_count;
      endcase
      // A result offered to a full buffer is lost; remember it until reset.
      if (in_valid_i && w_full) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign in_ready_o    = ~w_full;
  assign out_valid_o   = ~w_empty;
  assign out_id_o      = w_empty ? '0   : r_mem_id[r_rd_ptr];
  assign out_data_o    = w_empty ? '0   : r_mem_data[r_rd_ptr];
  assign out_we_o      = w_empty ? 1'b0 : r_mem_we[r_rd_ptr];
  // Close issue one entry early so an in-flight multi-cycle op still has a slot.
  assign issue_stall_o = (r_count >= c_stall);
  assign count_o       = r_count;
  assign overflow_o    = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_cvxif_result_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cvxif_result_buffer
//  Purpose  : Self-checking bench for cvxif_result_buffer. Expected results
//             are queued when issued; a monitor pops and compares on every
//             output handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cvxif_result_buffer;

  localparam int IDW = cvxif_pkg::X_ID_WIDTH;
  localparam int DW  = 64;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [DW-1:0]  data;
    logic           we;
  } item_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic [IDW-1:0] in_id = '0;
  logic [DW-1:0]  in_data = '0;
  logic           in_we = 1'b0;
  logic           in_ready;
  logic           out_valid;
  logic [IDW-1:0] out_id;
  logic [DW-1:0]  out_data;
  logic           out_we;
  logic           out_ready = 1'b0;
  logic           issue_stall;
  logic [2:0]     count;
  logic           overflow;

  item_t exp_q[$];
  int    tests = 0;
  int    fails = 0;

  always #5 clk = ~clk;

  cvxif_result_buffer #(
    .Depth(4), .DataWidth(DW), .IdWidth(IDW)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .in_valid_i   (in_valid),
    .in_id_i      (in_id),
    .in_data_i    (in_data),
    .in_we_i      (in_we),
    .in_ready_o   (in_ready),
    .out_valid_o  (out_valid),
    .out_id_o     (out_id),
    .out_data_o   (out_data),
    .out_we_o     (out_we),
    .out_ready_i  (out_ready),
    .issue_stall_o(issue_stall),
    .count_o      (count),
    .overflow_o   (overflow)
  );

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive a result that the bench expects to be accepted.
  task automatic drive(input logic [IDW-1:0] id, input logic [DW-1:0] data, input logic we, input bit expect_accept);
    item_t it;
    in_valid = 1'b1;
    in_id    = id;
    in_data  = data;
    in_we    = we;
    if (expect_accept) begin
      it.id = id; it.data = data; it.we = we;
      exp_q.push_back(it);
    end
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
    in_id    = '0;
    in_data  = '0;
    in_we    = 1'b0;
  endtask

  // Monitor: every output handshake must match the oldest expected result.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output_id", 64'(out_id), 64'hFFFF);
      end else begin
        item_t e;
        e = exp_q.pop_front();
        check("out_id",   64'(out_id), 64'(e.id));
        check("out_data", out_data,    e.data);
        check("out_we",   64'(out_we), 64'(e.we));
      end
    end
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_stall", 64'(issue_stall), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_out_data", out_data, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    step();

    // Single result, popped the cycle it appears
    out_ready = 1'b1;
    drive(4'd3, 64'hDEAD, 1'b1, 1'b1);
    check("no_bypass_valid", 64'(out_valid), 64'd0);
    step();
    idle_in();
    check("single_valid", 64'(out_valid), 64'd1);
    step();
    check("single_count", 64'(count), 64'd0);

    // Fill to full with CPU stalled, then overflow
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(IDW'(i), 64'h100 + 64'(i), 1'b1, 1'b1);
      step();
      check("fill_count", 64'(count), 64'(i + 1));
      check("fill_stall", 64'(issue_stall), (i + 1 >= 3) ? 64'd1 : 64'd0);
      check("fill_in_ready", 64'(in_ready), (i + 1 < 4) ? 64'd1 : 64'd0);
    end
    drive(4'd4, 64'h104, 1'b1, 1'b0);
    step();
    idle_in();
    check("ovf_flag", 64'(overflow), 64'd1);
    check("ovf_count", 64'(count), 64'd4);
    check("full_head_id", 64'(out_id), 64'd0);

    // Drain
    out_ready = 1'b1;
    step();
    check("pop_from_full_in_ready", 64'(in_ready), 64'd1);
    check("pop_from_full_count", 64'(count), 64'd3);
    repeat (3) step();
    check("drain_count", 64'(count), 64'd0);
    check("drain_ovf_sticky", 64'(overflow), 64'd1);
    check("drain_queue_empty", 64'(exp_q.size()), 64'd0);

    // Simultaneous push/pop at count 2 across pointer wraps
    out_ready = 1'b0;
    drive(4'd8, 64'h200, 1'b1, 1'b1); step();
    drive(4'd9, 64'h201, 1'b0, 1'b1); step();
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      drive(IDW'(k), 64'h202 + 64'(k), k[0], 1'b1);
      step();
      check("steady_count", 64'(count), 64'd2);
      check("steady_lag_data", out_data, 64'h201 + 64'(k));
    end
    idle_in();
    repeat (2) step();
    check("steady_drain_count", 64'(count), 64'd0);

    // we=0 passthrough
    drive(4'd5, 64'd0, 1'b0, 1'b1);
    step();
    idle_in();
    check("we0_id", 64'(out_id), 64'd5);
    check("we0_we", 64'(out_we), 64'd0);
    step();

    // Reset mid-stream with three entries held
    out_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      drive(IDW'(i), 64'h300 + 64'(i), 1'b1, 1'b1);
      step();
    end
    idle_in();
    check("pre_rst_count", 64'(count), 64'd3);
    #2;
    rst = 1'b1;
    #1;
    exp_q.delete();
    check("async_rst_valid", 64'(out_valid), 64'd0);
    check("async_rst_count", 64'(count), 64'd0);
    check("async_rst_in_ready", 64'(in_ready), 64'd1);
    check("async_rst_stall", 64'(issue_stall), 64'd0);
    check("async_rst_overflow", 64'(overflow), 64'd0);
    check("async_rst_id", 64'(out_id), 64'd0);
    step();
    rst = 1'b0;
    step();
    out_ready = 1'b1;
    drive(4'd7, 64'h777, 1'b1, 1'b1);
    step();
    idle_in();
    check("post_rst_first_id", 64'(out_id), 64'd7);
    step();
    check("post_rst_count", 64'(count), 64'd0);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Safety net in case the stimulus ever stalls.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
